multicycle_ctrl: RTL

//   Main controller for the multicycle RV32I-subset core. Sequences the shared ALU, register file and unified memory.

---
 rtl/mc_ctrl_pkg.sv | 77 +++++++
 rtl/mc_ctrl_fsm.sv | 54 +++++
 rtl/multicycle_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes, datapath selects
// and the ALU control decode. Optional bne support is enabled by defining MC_CTRL_BNE_EN.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W = 4;

   localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
   localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
   localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
   localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
   localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
   localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
   localparam logic [STATE_W-1:0] S_EXECUTER = 4'd6;
   localparam logic [STATE_W-1:0] S_EXECUTEI = 4'd7;
   localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
   localparam logic [STATE_W-1:0] S_BEQ      = 4'd9;
   localparam logic [STATE_W-1:0] S_JAL      = 4'd10;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // sub only for R-type (op[5]=1) with funct7b5 set; addi with that bit is still add
   function automatic logic [2:0] alu_ctrl(input logic [1:0] aluop, input logic [2:0] funct3,
                                           input logic op5, input logic f7b5);
      logic [2:0] r;
      r = ALUC_ADD;
      case (aluop)
         ALUOP_SUB: r = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  r = (op5 && f7b5) ? ALUC_SUB : ALUC_ADD;
               3'b010:  r = ALUC_SLT;
               3'b110:  r = ALUC_OR;
               3'b111:  r = ALUC_AND;
               default: r = ALUC_ADD;
            endcase
         end
         default: r = ALUC_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// State register and next-state logic of the multicycle controller.
// With MC_CTRL_BNE_EN defined, funct3=001 branches are also accepted.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               i_reset,
   input  logic [6:0]         i_op,
   input  logic [2:0]         i_funct3,
   output logic [STATE_W-1:0] o_state
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic               w_br_ok;

`ifdef MC_CTRL_BNE_EN
   assign w_br_ok = (i_funct3 == F3_BEQ) || (i_funct3 == F3_BNE);
`else
   assign w_br_ok = (i_funct3 == F3_BEQ);
`endif

   always_ff @(posedge clk) begin
      if (i_reset) r_state <= S_FETCH;
      else         r_state <= w_next;
   end

   // Any unlisted encoding falls to the default and recovers through FETCH
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            case (i_op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_BRANCH:    w_next = w_br_ok ? S_BEQ : S_FETCH;
               OP_JAL:       w_next = S_JAL;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset main controller: Moore output decode, ImmSrc and ALUControl.
// Define MC_CTRL_BNE_EN to add bne (PCWrite = ~zero for funct3=001).
module multicycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instrDone
);

   logic [STATE_W-1:0] w_state;
   logic [1:0]         w_aluop;
   logic               w_br_take;

   mc_ctrl_fsm u_fsm (
      .clk      (clk),
      .i_reset  (reset),
      .i_op     (op),
      .i_funct3 (funct3),
      .o_state  (w_state)
   );

`ifdef MC_CTRL_BNE_EN
   assign w_br_take = (funct3 == F3_BNE) ? ~zero : zero;
`else
   assign w_br_take = zero;
`endif

   // Per-state datapath controls; write enables are squashed while reset is high
   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      RegWrite  = 1'b0;
      instrDone = 1'b0;
      w_aluop   = ALUOP_ADD;
      case (w_state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            PCWrite   = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            w_aluop = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            w_aluop = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA   = SRCA_RS1;
            w_aluop   = ALUOP_SUB;
            PCWrite   = w_br_take;
            instrDone = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite   = 1'b0;
         IRWrite   = 1'b0;
         MemWrite  = 1'b0;
         RegWrite  = 1'b0;
         instrDone = 1'b0;
      end
   end

   always_comb begin
      case (op)
         OP_SW:     ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         default:   ImmSrc = IMM_I;
      endcase
   end

   assign ALUControl = alu_ctrl(w_aluop, funct3, op[5], funct7b5);

endmodule
